// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use and JALR hazards in ID,
// redirect squash, and a start/done handshake with the multi-cycle FPU in EX.
module hazard_controller #(
    parameter int REGFILE_LEN = 6,
    parameter int FPU_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REGFILE_LEN-1:0] id_rs1,
    input  logic [REGFILE_LEN-1:0] id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_jalr,
    input  logic                   imm_pc,
    input  logic [REGFILE_LEN-1:0] ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_fpu_multi,
    input  logic [REGFILE_LEN-1:0] mem_rd,
    input  logic                   mem_mem_read,
    input  logic                   fpu_done,
    output logic                   fpu_start,
    output logic                   pc_stall,
    output logic                   if_id_stall,
    output logic                   id_ex_stall,
    output logic                   ex_mem_flush,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   fpu_busy,
    output logic                   fpu_error,
    output logic [CNT_WIDTH-1:0]   stall_cycles
);

    localparam int TO_W = (FPU_TIMEOUT > 1) ? $clog2(FPU_TIMEOUT) : 1;

    typedef enum logic {
        ST_RUN,
        ST_FPU_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TO_W-1:0]        r_to_cnt;
    logic                   r_fpu_error;
    logic [CNT_WIDTH-1:0]   r_stall_cycles;

    logic w_lu;
    logic w_jl;
    logic w_timeout;
    logic w_release;

    // x0 is the only hardwired-zero index; FP registers (32-63) hazard normally.
    assign w_lu = ex_mem_read && (ex_rd != '0) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign w_jl = id_jalr && mem_mem_read && (mem_rd != '0) && (mem_rd == id_rs1);

    assign w_timeout = (r_state == ST_FPU_WAIT) && !fpu_done &&
                       (r_to_cnt == TO_W'(FPU_TIMEOUT - 1));
    assign w_release = (r_state == ST_FPU_WAIT) && (fpu_done || w_timeout);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:      if (ex_fpu_multi) w_next_state = ST_FPU_WAIT;
            ST_FPU_WAIT: if (w_release)    w_next_state = ST_RUN;
        endcase
    end

    // NOTE: every output gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        fpu_start    = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_flush = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        fpu_busy     = 1'b0;
        if (!rst) begin
            fpu_busy = (r_state == ST_FPU_WAIT);
            case (r_state)
                ST_RUN: begin
                    if (ex_fpu_multi) begin
                        fpu_start    = 1'b1;
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (w_lu || w_jl) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (imm_pc) begin
                        if_id_flush = 1'b1;
                    end
                end
                ST_FPU_WAIT: begin
                    // On release nothing is held: EX/MEM takes the result, ID/EX advances.
                    if (!w_release) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_RUN) && ex_fpu_multi) begin
            r_to_cnt <= '0;
        end else if ((r_state == ST_FPU_WAIT) && !fpu_done && !w_timeout) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpu_error <= 1'b0;
        end else if (w_timeout) begin
            r_fpu_error <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (pc_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
        end
    end

    assign fpu_error    = r_fpu_error;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_hazard_controller;

    localparam int RL   = 6;
    localparam int TO   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RL-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic          id_uses_rs1, id_uses_rs2, id_jalr, imm_pc;
    logic          ex_mem_read, ex_fpu_multi, mem_mem_read, fpu_done;
    logic          fpu_start, pc_stall, if_id_stall, id_ex_stall, ex_mem_flush;
    logic          if_id_flush, id_ex_flush, fpu_busy, fpu_error;
    logic [CW-1:0] stall_cycles;

    int tests  = 0;
    int errors = 0;
    bit en     = 1'b0;

    hazard_controller #(.REGFILE_LEN(RL), .FPU_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_jalr(id_jalr), .imm_pc(imm_pc),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_fpu_multi(ex_fpu_multi),
        .mem_rd(mem_rd), .mem_mem_read(mem_mem_read), .fpu_done(fpu_done),
        .fpu_start(fpu_start), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_flush(ex_mem_flush),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fpu_busy(fpu_busy), .fpu_error(fpu_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the FPU wait is tracked as "cycles since start".
    bit m_busy  = 1'b0;
    bit m_err   = 1'b0;
    int m_cnt   = 0;
    int m_cyc   = 0;
    int m_start = 0;

    always @(negedge clk) begin : model
        bit lu, jl, e_start, e_hold, e_lub, e_redir, done_now, timed_out;
        if (en) begin
            m_cyc++;
            check("m_fpu_error", fpu_error, m_err);
            check("m_stall_cycles", stall_cycles, m_cnt);
            lu = ex_mem_read && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
            jl = id_jalr && mem_mem_read && (mem_rd != 0) && (mem_rd == id_rs1);
            e_start = 0; e_hold = 0; e_lub = 0; e_redir = 0;
            timed_out = 0; done_now = 0;
            if (!rst) begin
                if (m_busy) begin
                    timed_out = !fpu_done && (m_cyc - m_start == TO);
                    done_now  = fpu_done || timed_out;
                    e_hold    = !done_now;
                end else if (ex_fpu_multi) begin
                    e_start = 1; e_hold = 1;
                end else if (lu || jl) begin
                    e_lub = 1;
                end else if (imm_pc) begin
                    e_redir = 1;
                end
            end
            check("m_fpu_start", fpu_start, e_start);
            check("m_pc_stall", pc_stall, e_hold || e_lub);
            check("m_if_id_stall", if_id_stall, e_hold || e_lub);
            check("m_id_ex_stall", id_ex_stall, e_hold);
            check("m_ex_mem_flush", ex_mem_flush, e_hold);
            check("m_id_ex_flush", id_ex_flush, e_lub);
            check("m_if_id_flush", if_id_flush, e_redir);
            check("m_fpu_busy", fpu_busy, !rst && m_busy);
            if (rst) begin
                m_busy = 0; m_err = 0; m_cnt = 0;
            end else begin
                if ((e_hold || e_lub) && m_cnt < CMAX) m_cnt++;
                if (timed_out) m_err = 1;
                if (e_start) begin
                    m_busy = 1; m_start = m_cyc;
                end else if (done_now) begin
                    m_busy = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_jalr = 0; imm_pc = 0;
        ex_mem_read = 0; ex_fpu_multi = 0; mem_mem_read = 0; fpu_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    function automatic logic [RL-1:0] pick_reg();
        case ($urandom_range(0, 4))
            0:       return RL'(0);
            1:       return RL'(5);
            2:       return RL'(7);
            3:       return RL'(32);
            default: return RL'(33);
        endcase
    endfunction

    initial begin : stim
        int  n;
        bit  released;
        bit  prev_rst;
        clear_inputs();
        rst = 1;
        tick();
        en = 1;
        tick();
        @(negedge clk);
        check("rst_pc_stall", pc_stall, 0);
        check("rst_fpu_busy", fpu_busy, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_fpu_error", fpu_error, 0);
        tick();
        rst = 0;

        // Load-use on rs2
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        @(negedge clk);
        check("lu_pc_stall", pc_stall, 1);
        check("lu_if_id_stall", if_id_stall, 1);
        check("lu_id_ex_flush", id_ex_flush, 1);
        check("lu_id_ex_stall", id_ex_stall, 0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("lu_released", pc_stall, 0);
        check("lu_stall_cycles", stall_cycles, 1);

        // x0 never hazards; f0 (index 32) does
        tick();
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        @(negedge clk);
        check("x0_no_stall", pc_stall, 0);
        tick();
        ex_rd = 32; id_rs1 = 32;
        @(negedge clk);
        check("f0_stall", pc_stall, 1);
        tick();
        clear_inputs();

        // JALR operand: load in EX then in MEM, redirect held off until released
        id_jalr = 1; id_uses_rs1 = 1; id_rs1 = 7; imm_pc = 1;
        ex_mem_read = 1; ex_rd = 7;
        @(negedge clk);
        check("jalr_ex_stall", pc_stall, 1);
        check("jalr_ex_no_redirect", if_id_flush, 0);
        tick();
        ex_mem_read = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 7;
        @(negedge clk);
        check("jalr_mem_stall", pc_stall, 1);
        check("jalr_mem_no_redirect", if_id_flush, 0);
        tick();
        mem_mem_read = 0; mem_rd = 0;
        @(negedge clk);
        check("jalr_redirect", if_id_flush, 1);
        check("jalr_free", pc_stall, 0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("jalr_redirect_once", if_id_flush, 0);

        // FPU handshake, done four cycles after start
        do_reset();
        ex_fpu_multi = 1;
        @(negedge clk);
        check("fpu_start_pulse", fpu_start, 1);
        check("fpu_start_flush", ex_mem_flush, 1);
        check("fpu_start_not_busy", fpu_busy, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("fpu_wait_no_start", fpu_start, 0);
            check("fpu_wait_busy", fpu_busy, 1);
            check("fpu_wait_flush", ex_mem_flush, 1);
        end
        tick();
        fpu_done = 1;
        @(negedge clk);
        check("fpu_done_busy", fpu_busy, 1);
        check("fpu_done_flush", ex_mem_flush, 0);
        check("fpu_done_id_ex_stall", id_ex_stall, 0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("fpu_after_busy", fpu_busy, 0);
        check("fpu_after_start", fpu_start, 0);
        check("fpu_stall_cycles", stall_cycles, 4);

        // Timeout: fpu_done never comes
        do_reset();
        ex_fpu_multi = 1;
        n = 0;
        released = 0;
        for (int i = 0; i < 20 && !released; i++) begin
            @(negedge clk);
            if (pc_stall) n++;
            else begin
                released = 1;
                check("to_busy_on_release", fpu_busy, 1);
                check("to_err_pending", fpu_error, 0);
            end
            tick();
        end
        ex_fpu_multi = 0;
        check("to_released", released, 1);
        check("to_stalled_cycles", n, TO);
        @(negedge clk);
        check("to_error_set", fpu_error, 1);
        check("to_idle", fpu_busy, 0);
        check("to_stall_cycles", stall_cycles, TO);
        repeat (3) tick();
        @(negedge clk);
        check("to_error_sticky", fpu_error, 1);
        tick();
        rst = 1;
        @(negedge clk);
        check("to_rst_outputs", pc_stall, 0);
        tick();
        rst = 0;
        @(negedge clk);
        check("to_rst_error_clear", fpu_error, 0);

        // Reset in the middle of FPU_WAIT
        tick();
        ex_fpu_multi = 1;
        @(negedge clk);
        check("mid_start", fpu_start, 1);
        tick();
        @(negedge clk);
        check("mid_busy", fpu_busy, 1);
        tick();
        rst = 1;
        @(negedge clk);
        check("mid_rst_busy", fpu_busy, 0);
        check("mid_rst_stall", pc_stall, 0);
        check("mid_rst_flush", ex_mem_flush, 0);
        check("mid_rst_start", fpu_start, 0);
        tick();
        rst = 0;
        ex_fpu_multi = 0;
        @(negedge clk);
        check("mid_after_busy", fpu_busy, 0);
        check("mid_after_cnt", stall_cycles, 0);
        check("mid_after_start", fpu_start, 0);

        // Counter saturation
        tick();
        ex_mem_read = 1; ex_rd = 33; id_rs1 = 33; id_uses_rs1 = 1;
        repeat (CMAX + 3) tick();
        @(negedge clk);
        check("sat_all_ones", stall_cycles, CMAX);
        tick();
        clear_inputs();
        @(negedge clk);
        check("sat_hold", stall_cycles, CMAX);

        // Randomized traffic
        do_reset();
        prev_rst = 1;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            id_rs1       = pick_reg();
            id_rs2       = pick_reg();
            ex_rd        = pick_reg();
            mem_rd       = pick_reg();
            id_uses_rs1  = $urandom_range(0, 1);
            id_uses_rs2  = $urandom_range(0, 1);
            id_jalr      = ($urandom_range(0, 3) == 0);
            imm_pc       = ($urandom_range(0, 3) == 0);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            mem_mem_read = ($urandom_range(0, 2) == 0);
            ex_fpu_multi = !prev_rst && ($urandom_range(0, 9) == 0);
            fpu_done     = ($urandom_range(0, 5) == 0);
            prev_rst     = rst;
            tick();
        end
        clear_inputs();
        rst = 0;
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
